// File: rtl/pwm_timer.sv
// pwm_timer: memory-mapped PWM peripheral with prescaler, period-boundary shadowing of period/duty and a wrap flag.
// Build macro PWM_TIMER_IRQ_EN adds STATUS.wrapFlag, CTRL.irqEn and the irq output; without it irq is tied low.
module pwm_timer #(
    parameter int CNT_WIDTH = 16,
    parameter int PRE_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic [4:0]  dmAddr,
    input  logic [31:0] dmWData,
    input  logic        memWrite,
    output logic [31:0] rData,
    output logic        pwmOut,
    output logic        irq
);

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_PERIOD = 3'd1;
    localparam logic [2:0] A_DUTY   = 3'd2;
    localparam logic [2:0] A_COUNT  = 3'd3;
    localparam logic [2:0] A_PRESC  = 3'd4;
    localparam logic [2:0] A_STATUS = 3'd5;

    logic [2:0]           addr_idx;
    logic                 we;
    logic                 wr_ctrl;
    logic                 wr_period;
    logic                 wr_duty;
    logic                 wr_presc;

    logic                 en_q, en_d;
    logic                 inv_q, inv_d;
    logic [CNT_WIDTH-1:0] period_pend_q, period_pend_d;
    logic [CNT_WIDTH-1:0] duty_pend_q, duty_pend_d;
    logic [CNT_WIDTH-1:0] period_act_q, period_act_d;
    logic [CNT_WIDTH-1:0] duty_act_q, duty_act_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [PRE_WIDTH-1:0] presc_q, presc_d;
    logic [PRE_WIDTH-1:0] pre_q, pre_d;
    logic                 pwm_q, pwm_d;

    logic                 tick;
    logic                 wrap;
    logic                 irq_en_rd;
    logic                 wrap_flag_rd;

    // Only word-aligned offsets are decoded; the low address bits and unused data bits are don't-care.
    logic                 unused_bits;
    assign unused_bits = ^{dmAddr[1:0], dmWData};

    always_comb begin
        addr_idx  = dmAddr[4:2];
        we        = sel && memWrite;
        wr_ctrl   = we && (addr_idx == A_CTRL);
        wr_period = we && (addr_idx == A_PERIOD);
        wr_duty   = we && (addr_idx == A_DUTY);
        wr_presc  = we && (addr_idx == A_PRESC);
    end

    always_comb begin
        en_d          = en_q;
        inv_d         = inv_q;
        period_pend_d = period_pend_q;
        duty_pend_d   = duty_pend_q;
        presc_d       = presc_q;
        if (wr_ctrl) begin
            en_d  = dmWData[0];
            inv_d = dmWData[1];
        end
        if (wr_period) begin
            period_pend_d = dmWData[CNT_WIDTH-1:0];
        end
        if (wr_duty) begin
            duty_pend_d = dmWData[CNT_WIDTH-1:0];
        end
        if (wr_presc) begin
            presc_d = dmWData[PRE_WIDTH-1:0];
        end
    end

    // Using >= keeps the prescaler from running past a PRESC that was lowered mid-count.
    always_comb begin
        tick         = en_q && (pre_q >= presc_q);
        wrap         = tick && (count_q == period_act_q);
        pre_d        = pre_q;
        count_d      = count_q;
        period_act_d = period_act_q;
        duty_act_d   = duty_act_q;
        if (!en_q) begin
            // Disabled: timebase parked at 0, so the 0->1 enable write starts from a clean period.
            pre_d        = '0;
            count_d      = '0;
            period_act_d = period_pend_q;
            duty_act_d   = duty_pend_q;
        end else begin
            if (tick) begin
                pre_d = '0;
            end else begin
                pre_d = pre_q + PRE_WIDTH'(1);
            end
            if (wrap) begin
                count_d      = '0;
                period_act_d = period_pend_q;
                duty_act_d   = duty_pend_q;
            end else if (tick) begin
                count_d = count_q + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        pwm_d = (en_q && (count_q < duty_act_q)) ^ inv_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q          <= 1'b0;
            inv_q         <= 1'b0;
            period_pend_q <= '0;
            duty_pend_q   <= '0;
            period_act_q  <= '0;
            duty_act_q    <= '0;
            count_q       <= '0;
            presc_q       <= '0;
            pre_q         <= '0;
            pwm_q         <= 1'b0;
        end else begin
            en_q          <= en_d;
            inv_q         <= inv_d;
            period_pend_q <= period_pend_d;
            duty_pend_q   <= duty_pend_d;
            period_act_q  <= period_act_d;
            duty_act_q    <= duty_act_d;
            count_q       <= count_d;
            presc_q       <= presc_d;
            pre_q         <= pre_d;
            pwm_q         <= pwm_d;
        end
    end

    assign pwmOut = pwm_q;

`ifdef PWM_TIMER_IRQ_EN
    logic wr_status;
    logic irq_en_q, irq_en_d;
    logic wrap_flag_q, wrap_flag_d;
    logic irq_q, irq_d;

    // A wrap in the same cycle as a W1C keeps the flag set.
    always_comb begin
        wr_status   = we && (addr_idx == A_STATUS);
        irq_en_d    = irq_en_q;
        wrap_flag_d = wrap_flag_q;
        if (wr_ctrl) begin
            irq_en_d = dmWData[2];
        end
        if (wrap) begin
            wrap_flag_d = 1'b1;
        end else if (wr_status && dmWData[0]) begin
            wrap_flag_d = 1'b0;
        end
        irq_d = wrap_flag_q && irq_en_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_en_q    <= 1'b0;
            wrap_flag_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            irq_en_q    <= irq_en_d;
            wrap_flag_q <= wrap_flag_d;
            irq_q       <= irq_d;
        end
    end

    assign irq          = irq_q;
    assign irq_en_rd    = irq_en_q;
    assign wrap_flag_rd = wrap_flag_q;
`else
    assign irq          = 1'b0;
    assign irq_en_rd    = 1'b0;
    assign wrap_flag_rd = 1'b0;
`endif

    always_comb begin
        rData = '0;
        if (sel) begin
            case (addr_idx)
                A_CTRL:   rData[2:0]           = {irq_en_rd, inv_q, en_q};
                A_PERIOD: rData[CNT_WIDTH-1:0] = period_pend_q;
                A_DUTY:   rData[CNT_WIDTH-1:0] = duty_pend_q;
                A_COUNT:  rData[CNT_WIDTH-1:0] = count_q;
                A_PRESC:  rData[PRE_WIDTH-1:0] = presc_q;
                A_STATUS: rData[0]             = wrap_flag_rd;
                default:  rData                = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_timer.sv
// Self-checking bench for pwm_timer: directed scenarios plus randomized period/duty/prescale
// configurations checked against closed-form period and high-time arithmetic.
module tb_pwm_timer;

`ifdef PWM_TIMER_IRQ_EN
    localparam bit HAS_IRQ = 1'b1;
`else
    localparam bit HAS_IRQ = 1'b0;
`endif

    localparam logic [4:0] R_CTRL   = 5'h00;
    localparam logic [4:0] R_PERIOD = 5'h04;
    localparam logic [4:0] R_DUTY   = 5'h08;
    localparam logic [4:0] R_COUNT  = 5'h0C;
    localparam logic [4:0] R_PRESC  = 5'h10;
    localparam logic [4:0] R_STATUS = 5'h14;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic [4:0]  dmAddr;
    logic [31:0] dmWData;
    logic        memWrite;
    logic [31:0] rData;
    logic        pwmOut;
    logic        irq;

    int errors = 0;
    int checks = 0;
    logic samp [0:255];

    pwm_timer #(.CNT_WIDTH(16), .PRE_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .sel(sel), .dmAddr(dmAddr), .dmWData(dmWData),
        .memWrite(memWrite), .rData(rData), .pwmOut(pwmOut), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; memWrite = 1'b1; dmAddr = a; dmWData = d;
        @(posedge clk);
        #1;
        sel = 1'b0; memWrite = 1'b0;
    endtask

    task automatic read_reg(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; memWrite = 1'b0; dmAddr = a;
        #1;
        d = rData;
        sel = 1'b0;
    endtask

    task automatic program_pwm(input int p, input int d, input int s, input logic [31:0] ctrl);
        write_reg(R_CTRL, 32'h0);
        write_reg(R_PRESC, s);
        write_reg(R_PERIOD, p);
        write_reg(R_DUTY, d);
        write_reg(R_CTRL, ctrl);
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            samp[i] = pwmOut;
        end
    endtask

    task automatic wait_rise(output bit ok);
        logic prev;
        ok = 1'b0;
        @(negedge clk);
        prev = pwmOut;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (prev == 1'b0 && pwmOut == 1'b1) begin
                ok = 1'b1;
                return;
            end
            prev = pwmOut;
        end
    endtask

    function automatic int count_level(input int start, input int len, input logic lvl);
        int c = 0;
        for (int i = start; i < start + len; i++) if (samp[i] === lvl) c++;
        return c;
    endfunction

    function automatic bit is_periodic(input int t);
        for (int i = 0; i < t; i++) if (samp[i] !== samp[i + t]) return 1'b0;
        return 1'b1;
    endfunction

    // Active clocks per period = min(DUTY, PERIOD+1) * (PRESC+1).
    function automatic int exp_high(input int p, input int d, input int s);
        return ((d < p + 1) ? d : p + 1) * (s + 1);
    endfunction

    // Expected level at idx clocks after a period start, PERIOD=9/PRESC=0, per-period duties d0,d1,d2.
    function automatic logic pat(input int idx, input int d0, input int d1, input int d2);
        int per = idx / 10;
        int pos = idx % 10;
        int d = (per == 0) ? d0 : ((per == 1) ? d1 : d2);
        return (pos < d);
    endfunction

    task automatic test_reset;
        logic [31:0] r;
        logic [4:0] addrs [6];
        addrs = '{R_CTRL, R_PERIOD, R_DUTY, R_COUNT, R_PRESC, R_STATUS};
        rst = 1'b0;
        repeat (3) @(posedge clk);
        write_reg(R_PRESC, 32'h3);
        write_reg(R_PERIOD, 32'h9);
        write_reg(R_DUTY, 32'h3);
        write_reg(R_STATUS, 32'h1);
        write_reg(R_CTRL, 32'h7);
        for (int i = 0; i < 6; i++) begin
            read_reg(addrs[i], r);
            checks++;
            if (r !== 32'h0) begin errors++; $display("FAIL reset_read_in_rst[%0h]: got %h expected 0", addrs[i], r); end
        end
        checks++;
        if (pwmOut !== 1'b0 || irq !== 1'b0) begin
            errors++; $display("FAIL reset_outputs: pwmOut=%b irq=%b expected 0/0", pwmOut, irq);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            read_reg(addrs[i], r);
            checks++;
            if (r !== 32'h0) begin errors++; $display("FAIL reset_read_after[%0h]: got %h expected 0", addrs[i], r); end
        end
    endtask

    task automatic test_regs;
        logic [31:0] r;
        logic [31:0] dv;
        dv = $urandom;
        write_reg(R_PERIOD, 32'hABCD_1234);
        write_reg(R_DUTY, dv);
        write_reg(R_PRESC, 32'h0000_01FF);
        write_reg(R_CTRL, 32'h6);
        read_reg(R_PERIOD, r);
        checks++;
        if (r !== 32'h1234) begin errors++; $display("FAIL reg_period: got %h expected 00001234", r); end
        read_reg(R_DUTY, r);
        checks++;
        if (r !== {16'h0, dv[15:0]}) begin errors++; $display("FAIL reg_duty: got %h expected %h", r, {16'h0, dv[15:0]}); end
        read_reg(R_PRESC, r);
        checks++;
        if (r !== 32'hFF) begin errors++; $display("FAIL reg_presc: got %h expected 000000ff", r); end
        read_reg(R_CTRL, r);
        checks++;
        if (r !== (HAS_IRQ ? 32'h6 : 32'h2)) begin errors++; $display("FAIL reg_ctrl: got %h expected %h", r, HAS_IRQ ? 32'h6 : 32'h2); end
        read_reg(5'h05, r);
        checks++;
        if (r !== 32'h1234) begin errors++; $display("FAIL reg_low_addr_bits: got %h expected 00001234", r); end
        write_reg(5'h18, 32'hFFFF_FFFF);
        read_reg(5'h18, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL reg_unmapped: got %h expected 0", r); end
        read_reg(R_PERIOD, r);
        checks++;
        if (r !== 32'h1234) begin errors++; $display("FAIL reg_unmapped_side_effect: got %h expected 00001234", r); end
        @(negedge clk);
        sel = 1'b0; dmAddr = R_PERIOD;
        #1;
        checks++;
        if (rData !== 32'h0) begin errors++; $display("FAIL reg_nosel: got %h expected 0", rData); end
        write_reg(R_CTRL, 32'h0);
    endtask

    task automatic test_basic_pwm;
        logic [31:0] r, prev;
        program_pwm(9, 3, 0, 32'h1);
        repeat (4) @(negedge clk);
        capture(20);
        checks++;
        if (count_level(0, 10, 1'b1) != 3) begin errors++; $display("FAIL basic_high: got %0d expected 3", count_level(0, 10, 1'b1)); end
        checks++;
        if (!is_periodic(10)) begin errors++; $display("FAIL basic_period: got aperiodic expected period 10"); end
        read_reg(R_COUNT, prev);
        for (int i = 0; i < 19; i++) begin
            read_reg(R_COUNT, r);
            checks++;
            if (r !== (prev + 1) % 10) begin errors++; $display("FAIL basic_count_sweep: got %0d expected %0d", r, (prev + 1) % 10); end
            prev = r;
        end
    endtask

    task automatic test_presc_inv;
        program_pwm(4, 2, 1, 32'h3);
        repeat (4) @(negedge clk);
        capture(20);
        checks++;
        if (count_level(0, 10, 1'b0) != 4) begin errors++; $display("FAIL presc_inv_low: got %0d expected 4", count_level(0, 10, 1'b0)); end
        checks++;
        if (!is_periodic(10)) begin errors++; $display("FAIL presc_inv_period: got aperiodic expected period 10"); end
    endtask

    task automatic test_shadow;
        bit ok;
        int bad;
        program_pwm(9, 3, 0, 32'h1);
        wait_rise(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL shadow_mid_sync: got no rising edge expected one"); end
        fork
            capture(29);
            begin
                @(negedge clk);
                write_reg(R_DUTY, 32'd7);
            end
        join
        bad = 0;
        for (int i = 0; i < 29; i++) if (samp[i] !== pat(i + 1, 3, 7, 7)) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL shadow_mid_period: got %0d wrong samples expected 0", bad); end

        program_pwm(9, 3, 0, 32'h1);
        wait_rise(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL shadow_wrap_sync: got no rising edge expected one"); end
        fork
            capture(29);
            begin
                repeat (7) @(negedge clk);
                write_reg(R_DUTY, 32'd7);
            end
        join
        bad = 0;
        for (int i = 0; i < 29; i++) if (samp[i] !== pat(i + 1, 3, 3, 7)) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL shadow_on_wrap: got %0d wrong samples expected 0", bad); end
    endtask

    task automatic test_boundaries;
        logic [31:0] r;
        program_pwm(9, 0, 0, 32'h1);
        repeat (3) @(negedge clk);
        capture(30);
        checks++;
        if (count_level(0, 30, 1'b1) != 0) begin errors++; $display("FAIL bound_duty0: got %0d high expected 0", count_level(0, 30, 1'b1)); end
        program_pwm(9, 12, 0, 32'h1);
        repeat (3) @(negedge clk);
        capture(30);
        checks++;
        if (count_level(0, 30, 1'b1) != 30) begin errors++; $display("FAIL bound_duty_gt_period: got %0d high expected 30", count_level(0, 30, 1'b1)); end
        program_pwm(0, 1, 0, 32'h1);
        repeat (3) @(negedge clk);
        capture(30);
        checks++;
        if (count_level(0, 30, 1'b1) != 30) begin errors++; $display("FAIL bound_period0: got %0d high expected 30", count_level(0, 30, 1'b1)); end
        program_pwm(9, 3, 0, 32'h3);
        repeat (5) @(negedge clk);
        write_reg(R_CTRL, 32'h2);
        @(negedge clk);
        read_reg(R_COUNT, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL bound_disable_count: got %0d expected 0", r); end
        checks++;
        if (pwmOut !== 1'b1) begin errors++; $display("FAIL bound_disable_pwm: got %b expected 1", pwmOut); end
    endtask

    task automatic test_random;
        int p, d, s, t, h;
        logic inv;
        for (int it = 0; it < 8; it++) begin
            p = $urandom_range(0, 15);
            d = $urandom_range(0, 20);
            s = $urandom_range(0, 3);
            inv = 1'($urandom_range(0, 1));
            program_pwm(p, d, s, {30'h0, inv, 1'b1});
            repeat (4) @(negedge clk);
            t = (p + 1) * (s + 1);
            h = exp_high(p, d, s);
            capture(2 * t);
            checks++;
            if (count_level(0, t, ~inv) != h) begin
                errors++; $display("FAIL rand_high[p=%0d d=%0d s=%0d inv=%b]: got %0d expected %0d", p, d, s, inv, count_level(0, t, ~inv), h);
            end
            checks++;
            if (!is_periodic(t)) begin
                errors++; $display("FAIL rand_period[p=%0d d=%0d s=%0d]: got aperiodic expected period %0d", p, d, s, t);
            end
        end
    endtask

    task automatic test_irq;
        logic [31:0] r;
        logic exp_irq [9:13];
        logic exp_st  [9:13];
        exp_irq = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        exp_st  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        write_reg(R_CTRL, 32'h0);
        write_reg(R_PRESC, 32'h0);
        write_reg(R_PERIOD, 32'h3);
        write_reg(R_DUTY, 32'h1);
        write_reg(R_STATUS, 32'h1);
        read_reg(R_STATUS, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL irq_status_cleared: got %h expected 0", r); end
        write_reg(R_CTRL, 32'h5);
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            checks++;
            if (irq !== (HAS_IRQ && k == 5)) begin errors++; $display("FAIL irq_rise[cycle %0d]: got %b expected %b", k, irq, HAS_IRQ && k == 5); end
        end
        repeat (2) @(negedge clk);
        write_reg(R_STATUS, 32'h1);
        for (int k = 9; k <= 13; k++) begin
            @(negedge clk);
            sel = 1'b1; memWrite = 1'b0; dmAddr = R_STATUS;
            #1;
            checks++;
            if (irq !== (HAS_IRQ & exp_irq[k])) begin errors++; $display("FAIL irq_w1c[cycle %0d]: got %b expected %b", k, irq, HAS_IRQ & exp_irq[k]); end
            checks++;
            if (rData !== {31'h0, HAS_IRQ & exp_st[k]}) begin errors++; $display("FAIL status_w1c[cycle %0d]: got %h expected %0d", k, rData, HAS_IRQ & exp_st[k]); end
            sel = 1'b0;
        end
        @(negedge clk);
        write_reg(R_STATUS, 32'h1);
        for (int k = 16; k <= 19; k++) begin
            @(negedge clk);
            checks++;
            if (irq !== HAS_IRQ) begin errors++; $display("FAIL irq_w1c_on_wrap[cycle %0d]: got %b expected %b", k, irq, HAS_IRQ); end
        end
        read_reg(R_CTRL, r);
        checks++;
        if (r !== (HAS_IRQ ? 32'h5 : 32'h1)) begin errors++; $display("FAIL irq_ctrl_read: got %h expected %h", r, HAS_IRQ ? 32'h5 : 32'h1); end
    endtask

    task automatic test_async_reset;
        logic [31:0] r;
        program_pwm(9, 12, 0, 32'h1);
        repeat (3) @(negedge clk);
        checks++;
        if (pwmOut !== 1'b1) begin errors++; $display("FAIL areset_pre: got %b expected 1", pwmOut); end
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (pwmOut !== 1'b0 || irq !== 1'b0) begin errors++; $display("FAIL areset_outputs: pwmOut=%b irq=%b expected 0/0", pwmOut, irq); end
        sel = 1'b1; dmAddr = R_PERIOD;
        #1;
        checks++;
        if (rData !== 32'h0) begin errors++; $display("FAIL areset_period: got %h expected 0", rData); end
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        read_reg(R_CTRL, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL areset_ctrl: got %h expected 0", r); end
    endtask

    initial begin
        rst = 1'b0; sel = 1'b0; memWrite = 1'b0; dmAddr = '0; dmWData = '0;
        test_reset();
        test_regs();
        test_basic_pwm();
        test_presc_inv();
        test_shadow();
        test_boundaries();
        test_random();
        test_irq();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
